alu: RTL and testbench

32-bit integer arithmetic/logic unit for the CPU execute stage. Takes two operands and a 4-bit operation code, and produces a registered 32-bit result, a zero flag and a valid strobe one clock later. Supports add, subtract, AND, OR, XOR, unsigned and signed set-less-than, and logical/arithmetic shifts.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_shifter.sv | 21 ++
 rtl/alu.sv | 116 +++++++++++
 tb/tb_alu.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode, width and shifter-mode constants for the execute-stage ALU.
package alu_pkg;

  localparam int ALU_W = 32;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLTU = 4'b0101;
  localparam logic [3:0] ALU_SLT  = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  localparam logic [1:0] SH_SLL = 2'd0;
  localparam logic [1:0] SH_SRL = 2'd1;
  localparam logic [1:0] SH_SRA = 2'd2;

endpackage

// File: rtl/alu_shifter.sv
// Combinational barrel shifter for SLL/SRL/SRA; zero latency, no flow control.
module alu_shifter
  import alu_pkg::*;
(
  input  logic [ALU_W-1:0] din,
  input  logic [4:0]       shamt,
  input  logic [1:0]       mode,
  output logic [ALU_W-1:0] dout
);

  always_comb begin
    dout = din;
    case (mode)
      SH_SLL:  dout = din << shamt;
      SH_SRL:  dout = din >> shamt;
      SH_SRA:  dout = $signed(din) >>> shamt;
      default: dout = din;
    endcase
  end

endmodule

// File: rtl/alu.sv
// 32-bit execute-stage ALU, 1-cycle registered result, one op per cycle, no backpressure.
// ALU_EXT_FLAGS_EN adds registered carry/overflow/negative flags.
module alu
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [ALU_W-1:0] in0,
  input  logic [ALU_W-1:0] in1,
  input  logic [3:0]       ALU_op,
  output logic [ALU_W-1:0] result,
  output logic             zero_flag,
  output logic             out_valid
`ifdef ALU_EXT_FLAGS_EN
  ,
  output logic             carry_flag,
  output logic             overflow_flag,
  output logic             negative_flag
`endif
);

  logic [ALU_W-1:0] add_res;
  logic [ALU_W-1:0] sub_res;
  logic             sub_borrow;
  logic             slt;
  logic [1:0]       sh_mode;
  logic [ALU_W-1:0] sh_res;
  logic [ALU_W-1:0] nxt_result;

`ifdef ALU_EXT_FLAGS_EN
  logic add_carry;
  logic nxt_carry;
  logic nxt_overflow;
  assign {add_carry, add_res} = {1'b0, in0} + {1'b0, in1};
`else
  assign add_res = in0 + in1;
`endif

  // The subtract borrow doubles as the unsigned less-than result.
  assign {sub_borrow, sub_res} = {1'b0, in0} - {1'b0, in1};
  assign slt = $signed(in0) < $signed(in1);

  always_comb begin
    sh_mode = SH_SLL;
    if (ALU_op == ALU_SRL) sh_mode = SH_SRL;
    else if (ALU_op == ALU_SRA) sh_mode = SH_SRA;
  end

  alu_shifter u_shifter (
    .din   (in0),
    .shamt (in1[4:0]),
    .mode  (sh_mode),
    .dout  (sh_res)
  );

  always_comb begin
    nxt_result = '0;
    case (ALU_op)
      ALU_ADD:  nxt_result = add_res;
      ALU_SUB:  nxt_result = sub_res;
      ALU_AND:  nxt_result = in0 & in1;
      ALU_OR:   nxt_result = in0 | in1;
      ALU_XOR:  nxt_result = in0 ^ in1;
      ALU_SLTU: nxt_result = {{(ALU_W-1){1'b0}}, sub_borrow};
      ALU_SLT:  nxt_result = {{(ALU_W-1){1'b0}}, slt};
      ALU_SLL,
      ALU_SRL,
      ALU_SRA:  nxt_result = sh_res;
      default:  nxt_result = '0;
    endcase
  end

`ifdef ALU_EXT_FLAGS_EN
  always_comb begin
    nxt_carry    = 1'b0;
    nxt_overflow = 1'b0;
    case (ALU_op)
      ALU_ADD: begin
        nxt_carry    = add_carry;
        nxt_overflow = (in0[ALU_W-1] == in1[ALU_W-1]) && (add_res[ALU_W-1] != in0[ALU_W-1]);
      end
      ALU_SUB: begin
        nxt_carry    = sub_borrow;
        nxt_overflow = (in0[ALU_W-1] != in1[ALU_W-1]) && (sub_res[ALU_W-1] != in0[ALU_W-1]);
      end
      default: ;
    endcase
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result    <= '0;
      zero_flag <= 1'b1;
      out_valid <= 1'b0;
`ifdef ALU_EXT_FLAGS_EN
      carry_flag    <= 1'b0;
      overflow_flag <= 1'b0;
      negative_flag <= 1'b0;
`endif
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        result    <= nxt_result;
        zero_flag <= (nxt_result == '0);
`ifdef ALU_EXT_FLAGS_EN
        carry_flag    <= nxt_carry;
        overflow_flag <= nxt_overflow;
        negative_flag <= nxt_result[ALU_W-1];
`endif
      end
    end
  end

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: one expected entry per clock edge, compared on the falling edge.
module tb_alu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in0;
  logic [31:0] in1;
  logic [3:0]  ALU_op;
  logic [31:0] result;
  logic        zero_flag;
  logic        out_valid;
`ifdef ALU_EXT_FLAGS_EN
  logic        carry_flag;
  logic        overflow_flag;
  logic        negative_flag;
`endif

  always #5 clk = ~clk;

  alu dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in0       (in0),
    .in1       (in1),
    .ALU_op    (ALU_op),
    .result    (result),
    .zero_flag (zero_flag),
    .out_valid (out_valid)
`ifdef ALU_EXT_FLAGS_EN
    ,
    .carry_flag    (carry_flag),
    .overflow_flag (overflow_flag),
    .negative_flag (negative_flag)
`endif
  );

  typedef struct {
    logic        vld;
    logic [31:0] res;
    logic        zero;
    logic        c;
    logic        v;
    logic        n;
  } exp_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        c;
    logic        v;
  } vec_t;

  exp_t sb_q[$];
  exp_t last_exp;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   mon_en   = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Independent reference: signed results via 64-bit arithmetic, shifts bit by bit.
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic c, output logic v);
    longint sa, sb, s;
    logic [63:0] u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = 32'h0; c = 1'b0; v = 1'b0;
    case (op)
      4'd0: begin
        u = {32'h0, a} + {32'h0, b}; r = u[31:0]; c = u[32];
        s = sa + sb; v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd1: begin
        r = a - b; c = (a < b);
        s = sa - sb; v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = (a < b) ? 32'd1 : 32'd0;
      4'd6: r = (sa < sb) ? 32'd1 : 32'd0;
      4'd7: begin r = a; for (int i = 0; i < int'(b[4:0]); i++) r = {r[30:0], 1'b0}; end
      4'd8: begin r = a; for (int i = 0; i < int'(b[4:0]); i++) r = {1'b0, r[31:1]}; end
      4'd9: begin r = a; for (int i = 0; i < int'(b[4:0]); i++) r = {r[31], r[31:1]}; end
      default: r = 32'h0;
    endcase
  endtask

  // Drive one cycle, then record what the DUT must show after that edge.
  task automatic step(input logic r, input logic vld, input logic [3:0] op,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] er, input logic ec, input logic ev);
    exp_t e;
    rst_n = r; in_valid = vld; ALU_op = op; in0 = a; in1 = b;
    @(posedge clk);
    if (!r) begin
      e.vld = 1'b0; e.res = 32'h0; e.zero = 1'b1; e.c = 1'b0; e.v = 1'b0; e.n = 1'b0;
      last_exp = e;
    end else if (vld) begin
      e.vld = 1'b1; e.res = er; e.zero = (er == 32'h0); e.c = ec; e.v = ev; e.n = er[31];
      last_exp = e;
    end else begin
      e = last_exp;
      e.vld = 1'b0;
    end
    sb_q.push_back(e);
    mon_en = 1'b1;
    #1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (sb_q.size() == 0) begin
        chk("sb_empty", 32'd0, 32'd1);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("out_valid", {31'd0, out_valid}, {31'd0, e.vld});
        chk("result", result, e.res);
        chk("zero_flag", {31'd0, zero_flag}, {31'd0, e.zero});
`ifdef ALU_EXT_FLAGS_EN
        chk("carry_flag", {31'd0, carry_flag}, {31'd0, e.c});
        chk("overflow_flag", {31'd0, overflow_flag}, {31'd0, e.v});
        chk("negative_flag", {31'd0, negative_flag}, {31'd0, e.n});
`endif
      end
    end
  end

  vec_t vecs[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r, a, b;
    logic c, v, vl;
    logic [3:0] op;

    rst_n = 1'b0; in_valid = 1'b0; ALU_op = 4'h0; in0 = '0; in1 = '0;
    last_exp = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0};

    vecs = '{
      '{4'h0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1},
      '{4'h0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0},
      '{4'h0, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b1},
      '{4'h1, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b1, 1'b0},
      '{4'h1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1},
      '{4'h1, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1'b1, 1'b1},
      '{4'h2, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b0, 1'b0},
      '{4'h2, 32'hAAAAAAAA, 32'h55555555, 32'h00000000, 1'b0, 1'b0},
      '{4'h3, 32'hAAAAAAAA, 32'h55555555, 32'hFFFFFFFF, 1'b0, 1'b0},
      '{4'h4, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'hFFFFFFFF, 1'b0, 1'b0},
      '{4'h5, 32'h00000001, 32'h00000002, 32'h00000001, 1'b0, 1'b0},
      '{4'h5, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b0},
      '{4'h5, 32'h7FFFFFFF, 32'h80000000, 32'h00000001, 1'b0, 1'b0},
      '{4'h6, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0},
      '{4'h6, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0},
      '{4'h7, 32'h00000001, 32'h00000002, 32'h00000004, 1'b0, 1'b0},
      '{4'h7, 32'hF0000000, 32'h0F000000, 32'hF0000000, 1'b0, 1'b0},
      '{4'h8, 32'h80000000, 32'hC0000000, 32'h80000000, 1'b0, 1'b0},
      '{4'h9, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0},
      '{4'h9, 32'h80000000, 32'h00000004, 32'hF8000000, 1'b0, 1'b0},
      '{4'hF, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b0, 1'b0},
      '{4'hA, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0}
    };

    step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'h3, 32'hFFFF0000, 32'h1, 32'h0, 1'b0, 1'b0);

    // Directed vectors issued back to back.
    foreach (vecs[i])
      step(1'b1, 1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].c, vecs[i].v);

    // Non-zero result, then idle cycles with changing inputs: outputs must hold.
    step(1'b1, 1'b1, 4'h0, 32'h00001234, 32'h00000001, 32'h00001235, 1'b0, 1'b0);
    step(1'b1, 1'b0, 4'h3, 32'hDEADBEEF, 32'h1, 32'h0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 4'hF, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 4'h4, 32'hFFFFFFFF, 32'h0000FFFF, 32'hFFFF0000, 1'b0, 1'b0);

    // Reset wins over a valid op in the same cycle.
    step(1'b0, 1'b1, 4'h3, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 4'h0, 32'h1, 32'h1, 32'h0, 1'b0, 1'b0);

    // Random stream against the reference model, valid mostly high.
    for (int i = 0; i < 300; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom();
      b  = $urandom();
      case ($urandom_range(0, 5))
        0: a = 32'h80000000;
        1: b = 32'hFFFFFFFF;
        2: b = a;
        default: ;
      endcase
      vl = ($urandom_range(0, 3) != 0);
      model(op, a, b, r, c, v);
      step(1'b1, vl, op, a, b, r, c, v);
    end

    @(negedge clk);
    #1;
    chk("sb_drain", sb_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
